// File: rtl/isp_stat_ae.sv
// rtl/isp_stat_ae.sv - windowed per-frame pixel count/sum statistics for auto-exposure
module isp_stat_ae #(
  parameter int BITS = 8
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_vsync,
  input  logic            in_href,
  input  logic [BITS-1:0] in_raw,
  input  logic [15:0]     win_x0,
  input  logic [15:0]     win_x1,
  input  logic [15:0]     win_y0,
  input  logic [15:0]     win_y1,
  output logic            out_vsync,
  output logic            out_href,
  output logic [BITS-1:0] out_raw,
  output logic            stat_done,
  output logic [31:0]     pix_cnt,
  output logic [31:0]     sum
);

  typedef enum logic [1:0] {IDLE, ACTIVE, PUBLISH} state_t;

  state_t      state, state_nx;
  logic        prev_vsync, prev_href, vs_seen;
  logic [15:0] x, y;
  logic [31:0] acc_cnt, acc_sum;
  logic        frame_start, frame_end, line_end, pix_valid, hit;
  logic        acc_clr, acc_en, publish;
  logic [32:0] sum_ext;
  logic [31:0] sum_floor;

  // vs_seen blocks a fake frame start right after reset (prev_vsync resets high
  // while a frame may still be in progress), so a partial frame is discarded.
  assign frame_start = vs_seen & prev_vsync & ~in_vsync;
  assign frame_end   = ~prev_vsync & in_vsync;
  assign line_end    = prev_href & ~in_href;
  assign pix_valid   = in_href & ~in_vsync;
  assign hit         = pix_valid & (x >= win_x0) & (x < win_x1) & (y >= win_y0) & (y < win_y1);
  assign sum_ext     = {1'b0, acc_sum} + {{(33-BITS){1'b0}}, in_raw};
  assign sum_floor   = (acc_sum < 32'd16) ? 32'd16 : acc_sum;

  // Pass-through: stream delayed by exactly one cycle
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_vsync <= 1'b1;
      out_href  <= 1'b0;
      out_raw   <= '0;
    end else begin
      out_vsync <= in_vsync;
      out_href  <= in_href;
      out_raw   <= in_raw;
    end
  end

  // Sync history for edge detection
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vsync <= 1'b1;
      prev_href  <= 1'b0;
      vs_seen    <= 1'b0;
    end else begin
      prev_vsync <= in_vsync;
      prev_href  <= in_href;
      if (in_vsync) vs_seen <= 1'b1;
    end
  end

  // Column counter: cleared between lines, advances after each valid pixel
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)                         x <= '0;
    else if (!in_href)                  x <= '0;
    else if (pix_valid && x != 16'hFFFF) x <= x + 16'd1;
  end

  // Row counter: cleared in blanking, advances on each line end
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)                         y <= '0;
    else if (in_vsync)                  y <= '0;
    else if (line_end && y != 16'hFFFF) y <= y + 16'd1;
  end

  // FSM state register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state and accumulator controls
  always_comb begin
    state_nx = state;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    publish  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nx = ACTIVE;
          acc_clr  = 1'b1;
        end
      end
      ACTIVE: begin
        if (frame_start)    acc_clr  = 1'b1;
        else if (frame_end) state_nx = PUBLISH;
        else                acc_en   = hit;
      end
      PUBLISH: begin
        publish  = 1'b1;
        acc_clr  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Saturating accumulators for the frame in progress
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
      acc_sum <= '0;
    end else if (acc_clr) begin
      acc_cnt <= '0;
      acc_sum <= '0;
    end else if (acc_en) begin
      if (acc_cnt != 32'hFFFF_FFFF) acc_cnt <= acc_cnt + 32'd1;
      acc_sum <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
    end
  end

  // Publish results; an empty frame leaves the previous report in place
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      stat_done <= 1'b0;
      pix_cnt   <= '0;
      sum       <= 32'd16;
    end else begin
      stat_done <= publish && (acc_cnt != 32'd0);
      if (publish && acc_cnt != 32'd0) begin
        pix_cnt <= acc_cnt;
        sum     <= sum_floor;
      end
    end
  end

endmodule
